// File: rtl/tick_timer.sv
// Turns the divided clocks into one-cycle tick strobes (sampled as data in the
// clk_in domain) and runs a loadable down-counter on the selected tick.
module tick_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clk_10KHz,
  input  logic             clk_100KHz,
  input  logic             tick_sel,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick_10k,
  output logic             tick_100k,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       w_div_in;
  logic [1:0]       w_tick;
  logic             w_sel_tick;
  logic             r_sel;
  logic             w_sel_next;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Bit 0 carries the 10 kHz source, bit 1 the 100 kHz source.
  assign w_div_in = {clk_100KHz, clk_10KHz};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      logic r_sync0;
      logic r_sync1;
      logic r_prev;
      logic r_tick;

      always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
          r_sync0 <= 1'b0;
          r_sync1 <= 1'b0;
          r_prev  <= 1'b0;
          r_tick  <= 1'b0;
        end else begin
          r_sync0 <= w_div_in[gi];
          r_sync1 <= r_sync0;
          r_prev  <= r_sync1;
          r_tick  <= r_sync1 & ~r_prev;
        end
      end

      assign w_tick[gi] = r_tick;
    end
  endgenerate

  assign tick_10k   = w_tick[0];
  assign tick_100k  = w_tick[1];
  assign w_sel_tick = r_sel ? w_tick[1] : w_tick[0];

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (load_val != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // Abort has priority over a tick arriving in the same cycle.
        if (stop) begin
          w_state_next = ST_IDLE;
        end else if (w_sel_tick && (r_count == CNT_W'(1))) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    w_sel_next   = r_sel;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_count_next = load_val;
          if (load_val != '0) begin
            w_sel_next = tick_sel;
          end
        end
      end
      ST_RUN: begin
        if (!stop && w_sel_tick && (r_count != '0)) begin
          w_count_next = r_count - CNT_W'(1);
        end
      end
      default: begin
        w_count_next = r_count;
        w_sel_next   = r_sel;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_sel   <= w_sel_next;
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;

endmodule

// File: tb/tb_tick_timer.sv
// Randomised scoreboard bench for tick_timer: expected ticks and timer events
// are derived from the divided-clock waveforms with plain arithmetic.
module tb_tick_timer;
  localparam int CNT_W = 16;
  localparam int MAXC  = 12000;
  localparam int KL    = 0;
  localparam int KD    = 1;
  localparam int KS    = 2;

  logic             clk_in = 1'b0;
  logic             reset = 1'b0;
  logic             clk_10KHz = 1'b0;
  logic             clk_100KHz = 1'b0;
  logic             tick_sel = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] load_val = '0;
  logic             tick_10k;
  logic             tick_100k;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  tick_timer #(.CNT_W(CNT_W)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .clk_10KHz (clk_10KHz),
    .clk_100KHz(clk_100KHz),
    .tick_sel  (tick_sel),
    .start     (start),
    .stop      (stop),
    .load_val  (load_val),
    .tick_10k  (tick_10k),
    .tick_100k (tick_100k),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int cyc;
    int kind;
    int cnt;
  } ev_t;

  int               cyc = 0;
  int               slot = 0;
  int               nxt = 0;
  int               checks = 0;
  int               failures = 0;
  bit               w100 [MAXC];
  bit               w10  [MAXC];
  bit               sch_st [MAXC];
  bit               sch_sp [MAXC];
  bit               sch_sel[MAXC];
  logic [CNT_W-1:0] sch_lv [MAXC];
  int               q100[$];
  int               q10[$];
  ev_t              evq[$];
  logic             pb = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit tv(input bit sel, input int t);
    if (t < 4 || t >= MAXC) return 1'b0;
    if (sel) return w100[t-3] && !w100[t-4];
    return w10[t-3] && !w10[t-4];
  endfunction

  function automatic int nth_tick(input bit sel, input int l, input int n);
    int k = 0;
    for (int t = l; t < MAXC - 8; t++) begin
      if (tv(sel, t)) begin
        k++;
        if (k == n) return t;
      end
    end
    return -1;
  endfunction

  function automatic int ticks_in(input bit sel, input int a, input int b);
    int k = 0;
    for (int t = a; t <= b; t++) if (tv(sel, t)) k++;
    return k;
  endfunction

  task automatic push_ev(input int c, input int k, input int n);
    ev_t ev;
    ev.cyc  = c;
    ev.kind = k;
    ev.cnt  = n;
    evq.push_back(ev);
  endtask

  task automatic gen_seg(input int s0, input int p100, input int p10);
    int ph1 = $urandom_range(p100 - 1, 0);
    int ph2 = $urandom_range(p10 - 1, 0);
    for (int c = s0; c < MAXC; c++) begin
      w100[c]    = (c >= s0 + 5) && (((c - s0 - 5 + ph1) % p100) < p100 / 2);
      w10[c]     = (c >= s0 + 5) && (((c - s0 - 5 + ph2) % p10) < p10 / 2);
      sch_st[c]  = 1'b0;
      sch_sp[c]  = 1'b0;
      sch_sel[c] = 1'b0;
      sch_lv[c]  = '0;
    end
  endtask

  // Drives the slot that follows the next rising edge of clk_in.
  task automatic step();
    int c;
    @(posedge clk_in);
    #1;
    c          = cyc;
    slot       = c;
    clk_100KHz = w100[c];
    clk_10KHz  = w10[c];
    if (c > 0 && w100[c] && !w100[c-1]) q100.push_back(c + 3);
    if (c > 0 && w10[c] && !w10[c-1]) q10.push_back(c + 3);
    start    = sch_st[c];
    stop     = sch_sp[c];
    load_val = sch_st[c] ? sch_lv[c] : CNT_W'($urandom);
    tick_sel = sch_st[c] ? sch_sel[c] : 1'($urandom);
  endtask

  task automatic run_until(input int target);
    while (slot < target) step();
  endtask

  task automatic plan_launch(input int n, input bit sel, input int stop_k, input bit extra);
    int f, l, e, s, endc, x, cnt;
    f          = nxt;
    sch_st[f]  = 1'b1;
    sch_lv[f]  = CNT_W'(n);
    sch_sel[f] = sel;
    if (extra) sch_sp[f] = 1'b1;
    l = f + 1;
    if (n == 0) begin
      push_ev(l, KD, 0);
      nxt = l + 1;
      if (extra) begin
        sch_st[l] = 1'b1;
        sch_lv[l] = CNT_W'($urandom_range(9, 1));
      end
    end else begin
      push_ev(l, KL, n);
      e = nth_tick(sel, l, n) + 1;
      if (e <= 0) begin
        $display("FAIL tick_search cyc=%0d actual=none expected=tick", cyc);
        $fatal(1);
      end
      if (stop_k != 0) begin
        s = (stop_k > 0) ? nth_tick(sel, l, stop_k) + 1 : $urandom_range(e, l + 1);
        sch_sp[s-1] = 1'b1;
        cnt = n - ticks_in(sel, l, s - 2);
        push_ev(s, KS, cnt);
        endc = s;
        nxt  = s;
      end else begin
        push_ev(e, KD, 0);
        endc = e;
        nxt  = e + 1;
        if (extra) begin
          sch_st[e] = 1'b1;
          sch_lv[e] = CNT_W'(7);
        end
      end
      if (extra) begin
        x          = $urandom_range(endc - 1, l);
        sch_st[x]  = 1'b1;
        sch_lv[x]  = CNT_W'(9);
        sch_sel[x] = ~sel;
      end
    end
    $display("LAUNCH slot=%0d load=%0d sel=%0d stop_k=%0d extra=%0d", f, n, sel, stop_k, extra);
    nxt += $urandom_range(3, 0);
    run_until(nxt - 1);
  endtask

  task automatic reset_mid(input int p100, input int p10);
    int f, l, c;
    f          = nxt;
    sch_st[f]  = 1'b1;
    sch_lv[f]  = CNT_W'(4);
    sch_sel[f] = 1'b1;
    l = f + 1;
    push_ev(l, KL, 4);
    c = l;
    while (4 - ticks_in(1'b1, l, c - 1) != 2 && c < MAXC - 20) c++;
    run_until(c);
    #2;
    reset = 1'b0;
    evq.delete();
    q100.delete();
    q10.delete();
    #1;
    chk("arst_tick10k", tick_10k, 0);
    chk("arst_tick100k", tick_100k, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", count, 0);
    $display("ARESET slot=%0d", c);
    gen_seg(c + 1, p100, p10);
    step();
    step();
    #2;
    reset = 1'b1;
    nxt = slot + 6;
  endtask

  // Monitor: compares every strobe and every timer event against the queues.
  always @(negedge clk_in) begin : monitor
    bit  e100, e10;
    int  kind;
    ev_t ev;
    if (!reset) begin
      pb <= 1'b0;
    end else begin
      e100 = (q100.size() > 0) && (q100[0] == cyc);
      if (e100) void'(q100.pop_front());
      if (e100 || tick_100k) chk("tick_100k", tick_100k, e100);
      e10 = (q10.size() > 0) && (q10[0] == cyc);
      if (e10) void'(q10.pop_front());
      if (e10 || tick_10k) chk("tick_10k", tick_10k, e10);
      if (done || (busy != pb)) begin
        kind = done ? KD : (busy ? KL : KS);
        if (evq.size() == 0) begin
          chk("unexpected_evt", kind, -1);
        end else begin
          ev = evq.pop_front();
          chk("evt_kind", kind, ev.kind);
          chk("evt_cyc", cyc, ev.cyc);
          chk("evt_count", count, ev.cnt);
          if (kind == KD) chk("done_busy", busy, 0);
          $display("EVENT kind=%0d cyc=%0d count=%0d", kind, cyc, count);
        end
      end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        ev = evq.pop_front();
        chk("missed_evt", cyc, -ev.cyc);
      end
      pb <= busy;
    end
  end

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    gen_seg(0, 10, 100);
    step();
    step();
    #1;
    chk("rst_tick10k", tick_10k, 0);
    chk("rst_tick100k", tick_100k, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    #1;
    reset = 1'b1;
    nxt = 8;

    plan_launch(5, 1'b1, 0, 1'b0);
    plan_launch(0, 1'b0, 0, 1'b0);
    plan_launch(5, 1'b1, 3, 1'b0);
    plan_launch(4, 1'b0, 0, 1'b1);
    plan_launch(0, 1'b1, 0, 1'b1);
    reset_mid($urandom_range(12, 6), $urandom_range(40, 20));

    for (int sg = 0; sg < 6; sg++) begin
      for (int k = 0; k < 6; k++) begin
        plan_launch($urandom_range(4, 0), 1'($urandom),
                    ($urandom_range(2, 0) == 0) ? -1 : 0, 1'($urandom));
      end
      if (sg < 5) reset_mid($urandom_range(12, 6), $urandom_range(40, 20));
    end

    run_until(slot + 20);
    chk("evq_empty", evq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
